// File: rtl/reu_pkg.sv
// reu_pkg: transfer-type codes and sequencer state encoding shared by the REU DMA sequencer.
package reu_pkg;
    localparam logic [1:0] XFER_STASH  = 2'b00;
    localparam logic [1:0] XFER_FETCH  = 2'b01;
    localparam logic [1:0] XFER_SWAP   = 2'b10;
    localparam logic [1:0] XFER_VERIFY = 2'b11;

    typedef enum logic [3:0] {
        IDLE, SETUP, C64RD, C64WR, RAMRD, RAMWR, CMP, STEP, END
    } SeqState;
endpackage

// File: rtl/reu_dma_seq_if.sv
// reu_dma_seq_if: register-block, C64-bus and SDRAM signals of the REU DMA sequencer.
// master is the sequencer side, slave is the surrounding system.
interface reu_dma_seq_if;
    logic       Execute;
    logic [1:0] XferType;
    logic       Length1;
    logic       BA;
    logic [7:0] C64DIn;
    logic [7:0] RAMDIn;
    logic       RAMAck;
    logic       DMA;
    logic       C64WE;
    logic [7:0] C64DOut;
    logic       RAMRD;
    logic       RAMWR;
    logic [7:0] RAMDOut;
    logic       IncCA;
    logic       IncREUA;
    logic       DecLen;
    logic       XferEnd;
    logic       SetEndOfBlock;
    logic       SetVerifyErr;
    logic       Busy;

    modport master (
        input  Execute, XferType, Length1, BA, C64DIn, RAMDIn, RAMAck,
        output DMA, C64WE, C64DOut, RAMRD, RAMWR, RAMDOut,
        output IncCA, IncREUA, DecLen, XferEnd, SetEndOfBlock, SetVerifyErr, Busy
    );

    modport slave (
        output Execute, XferType, Length1, BA, C64DIn, RAMDIn, RAMAck,
        input  DMA, C64WE, C64DOut, RAMRD, RAMWR, RAMDOut,
        input  IncCA, IncREUA, DecLen, XferEnd, SetEndOfBlock, SetVerifyErr, Busy
    );
endinterface

// File: rtl/reu_dma_seq.sv
// reu_dma_seq: REU DMA sequencer moving bytes between the C64 bus and REU RAM, clocked on falling PHI2.
// Define REU_SWAP_EN to build the swap transfer; otherwise a swap request ends immediately.
module reu_dma_seq
    import reu_pkg::*;
#(
    parameter int DMA_SETUP = 1
) (
    input logic PHI2,
    input logic Reset,
    reu_dma_seq_if.master bus
);
    SeqState    state, nextState;
    logic [1:0] xferType;
    logic [2:0] setupCnt;
    logic [7:0] bufA, bufB;
    logic       err, c64Wr, mismatch;

    function automatic SeqState firstAccess(input logic [1:0] t);
`ifdef REU_SWAP_EN
        return t == XFER_FETCH ? RAMRD : C64RD;
`else
        return t == XFER_FETCH ? RAMRD : t == XFER_SWAP ? END : C64RD;
`endif
    endfunction

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = bus.Execute ? SETUP : IDLE;
            SETUP:   nextState = setupCnt == 3'd1 ? firstAccess(xferType) : SETUP;
            C64RD:   if (bus.BA) nextState = xferType == XFER_STASH ? RAMWR : RAMRD;
            C64WR:   if (bus.BA) nextState = xferType == XFER_FETCH ? STEP : RAMWR;
            RAMRD:   if (bus.RAMAck) nextState = xferType == XFER_VERIFY ? CMP : C64WR;
            RAMWR:   if (bus.RAMAck) nextState = STEP;
            CMP:     nextState = STEP;
            STEP:    nextState = (bus.Length1 || err) ? END : firstAccess(xferType);
            default: nextState = IDLE;
        endcase
    end

    // Compare against the byte arriving now so the mismatch pulse lines up with CMP.
    assign mismatch = nextState == CMP && bufA != bus.RAMDIn;

    always_ff @(negedge PHI2 or posedge Reset) begin
        if (Reset) begin
            state             <= IDLE;
            xferType          <= XFER_STASH;
            setupCnt          <= '0;
            bufA              <= '0;
            bufB              <= '0;
            err               <= 1'b0;
            c64Wr             <= 1'b0;
            bus.DMA           <= 1'b0;
            bus.Busy          <= 1'b0;
            bus.RAMRD         <= 1'b0;
            bus.RAMWR         <= 1'b0;
            bus.IncCA         <= 1'b0;
            bus.IncREUA       <= 1'b0;
            bus.DecLen        <= 1'b0;
            bus.XferEnd       <= 1'b0;
            bus.SetEndOfBlock <= 1'b0;
            bus.SetVerifyErr  <= 1'b0;
        end else begin
            state <= nextState;
            if (state == IDLE && bus.Execute) begin
                xferType <= bus.XferType;
                setupCnt <= 3'(DMA_SETUP);
            end else if (state == SETUP) setupCnt <= setupCnt - 3'd1;
            if (state == C64RD && bus.BA) bufA <= bus.C64DIn;
            if (state == RAMRD && bus.RAMAck) bufB <= bus.RAMDIn;
            err               <= state == END ? 1'b0 : err | mismatch;
            c64Wr             <= nextState == C64WR;
            bus.DMA           <= nextState != IDLE;
            bus.Busy          <= nextState != IDLE;
            bus.RAMRD         <= nextState == RAMRD;
            bus.RAMWR         <= nextState == RAMWR;
            bus.IncCA         <= nextState == STEP;
            bus.IncREUA       <= nextState == STEP;
            bus.DecLen        <= nextState == STEP;
            bus.SetEndOfBlock <= nextState == STEP && bus.Length1;
            bus.SetVerifyErr  <= mismatch;
            bus.XferEnd       <= nextState == END;
        end
    end

    assign bus.C64WE   = c64Wr & bus.BA;
    assign bus.C64DOut = bufB;
    assign bus.RAMDOut = bufA;
endmodule

// File: tb/tb_reu_dma_seq.sv
// tb_reu_dma_seq: directed and random transfers against an event-list model of the REU sequencer.
// The environment emulates C64 memory, REU RAM with delayed acks, BA stalls and the length register.
module tb_reu_dma_seq;
    localparam int SETUP_CYC = 2;
    localparam logic [2:0] EV_RAMWR = 3'd1, EV_C64WR = 3'd2, EV_STEP = 3'd3;
    localparam logic [2:0] EV_VERR = 3'd4, EV_EOB = 3'd5, EV_END = 3'd6;
`ifdef REU_SWAP_EN
    localparam bit SWAP_EN = 1'b1;
`else
    localparam bit SWAP_EN = 1'b0;
`endif

    logic PHI2 = 1'b0;
    logic Reset;
    reu_dma_seq_if bus ();
    reu_dma_seq #(.DMA_SETUP(SETUP_CYC)) dut (.PHI2(PHI2), .Reset(Reset), .bus(bus));

    logic [7:0]  c64Mem [16];
    logic [7:0]  ramMem [16];
    logic [3:0]  ca, reua;
    logic [16:0] len;
    logic [10:0] got[$], want[$];
    int checks = 0, fails = 0, cyc = 0, ramWait = 0, ackDelay = 0, stall = 0, stallN = 0;
    int dmaRise = -1, rdRise = -1;
    bit baRand = 1'b0, endSeen = 1'b0, decPending = 1'b0;

    assign bus.C64DIn  = c64Mem[ca];
    assign bus.RAMDIn  = ramMem[reua];
    assign bus.Length1 = len == 17'd1;

    always #5 PHI2 = ~PHI2;

    // Bus environment on the rising edge, monitor 1ns later once BA-gated outputs settle.
    always @(posedge PHI2) begin
        cyc++;
        if (decPending) len--;
        decPending = 1'b0;
        if (stall > 0) begin
            bus.BA = 1'b0;
            stall--;
        end else bus.BA = baRand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.RAMAck) bus.RAMAck = 1'b0;
        else if (bus.RAMRD || bus.RAMWR) begin
            if (ramWait >= ackDelay) begin
                bus.RAMAck = 1'b1;
                ramWait = 0;
                if (bus.RAMWR) begin
                    got.push_back({EV_RAMWR, bus.RAMDOut});
                    ramMem[reua] = bus.RAMDOut;
                end else stall = stallN;
            end else ramWait++;
        end
        #1;
        if (bus.C64WE) begin
            got.push_back({EV_C64WR, bus.C64DOut});
            c64Mem[ca] = bus.C64DOut;
        end
        if (bus.IncCA || bus.IncREUA || bus.DecLen) begin
            got.push_back({EV_STEP, 5'd0, bus.IncCA, bus.IncREUA, bus.DecLen});
            ca++;
            reua++;
            decPending = bus.DecLen;
        end
        if (bus.SetVerifyErr) got.push_back({EV_VERR, 8'h00});
        if (bus.SetEndOfBlock) got.push_back({EV_EOB, 8'h00});
        if (bus.XferEnd) begin
            got.push_back({EV_END, 8'h00});
            endSeen = 1'b1;
        end
        if (bus.DMA && dmaRise < 0) dmaRise = cyc;
        if (bus.RAMRD && rdRise < 0) rdRise = cyc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected observable events for a transfer over memory addresses 0..n-1.
    task automatic buildModel(input logic [1:0] t, input int n);
        logic mis;
        want.delete();
        if (!(t == reu_pkg::XFER_SWAP && !SWAP_EN)) begin
            for (int i = 0; i < n; i++) begin
                mis = c64Mem[i] != ramMem[i];
                case (t)
                    reu_pkg::XFER_STASH: want.push_back({EV_RAMWR, c64Mem[i]});
                    reu_pkg::XFER_FETCH: want.push_back({EV_C64WR, ramMem[i]});
                    reu_pkg::XFER_SWAP: begin
                        want.push_back({EV_C64WR, ramMem[i]});
                        want.push_back({EV_RAMWR, c64Mem[i]});
                    end
                    default: if (mis) want.push_back({EV_VERR, 8'h00});
                endcase
                want.push_back({EV_STEP, 8'h07});
                if (i == n - 1) want.push_back({EV_EOB, 8'h00});
                if (i == n - 1 || (t == reu_pkg::XFER_VERIFY && mis)) break;
            end
        end
        want.push_back({EV_END, 8'h00});
    endtask

    task automatic fillRand();
        for (int i = 0; i < 16; i++) begin
            c64Mem[i] = 8'($urandom);
            ramMem[i] = $urandom_range(0, 1) ? c64Mem[i] : 8'($urandom);
        end
    endtask

    task automatic runXfer(input string name, input logic [1:0] t, input int n, input int ad,
                           input bit br, input bit intrude);
        ca = 0;
        reua = 0;
        len = 17'(n);
        decPending = 1'b0;
        ackDelay = ad;
        ramWait = 0;
        baRand = br;
        buildModel(t, n);
        got.delete();
        endSeen = 1'b0;
        dmaRise = -1;
        rdRise = -1;
        @(posedge PHI2);
        bus.Execute = 1'b1;
        bus.XferType = t;
        @(posedge PHI2);
        bus.Execute = 1'b0;
        #2;
        check({name, "_dma_rise"}, {bus.DMA, bus.Busy}, 2'b11);
        if (intrude) begin
            repeat (3) @(posedge PHI2);
            bus.Execute = 1'b1;
            bus.XferType = ~t;
            @(posedge PHI2);
            bus.Execute = 1'b0;
        end
        for (int i = 0; i < 3000 && !endSeen; i++) @(posedge PHI2);
        check({name, "_done"}, endSeen, 1'b1);
        @(posedge PHI2);
        #2;
        check({name, "_idle"}, {bus.DMA, bus.Busy}, 2'b00);
        repeat (2) @(posedge PHI2);
        #2;
        check({name, "_count"}, got.size(), want.size());
        for (int i = 0; i < want.size(); i++)
            check($sformatf("%s_ev%0d", name, i), i < got.size() ? got[i] : 11'bx, want[i]);
    endtask

    initial begin
        Reset = 1'b0;
        bus.Execute = 1'b0;
        bus.XferType = 2'b00;
        bus.BA = 1'b1;
        bus.RAMAck = 1'b0;
        ca = 0;
        reua = 0;
        len = 17'd0;
        for (int i = 0; i < 16; i++) begin
            c64Mem[i] = 8'h00;
            ramMem[i] = 8'h00;
        end
        #2 Reset = 1'b1;
        #1;
        check("rst_ctl", {bus.DMA, bus.Busy, bus.RAMRD, bus.RAMWR, bus.C64WE}, 5'd0);
        check("rst_pulse", {bus.IncCA, bus.IncREUA, bus.DecLen, bus.XferEnd,
                            bus.SetEndOfBlock, bus.SetVerifyErr}, 6'd0);
        check("rst_data", {bus.C64DOut, bus.RAMDOut}, 16'd0);
        @(posedge PHI2);
        #3 Reset = 1'b0;

        c64Mem[0] = 8'h11;
        c64Mem[1] = 8'h22;
        runXfer("stash", reu_pkg::XFER_STASH, 2, 2, 1'b0, 1'b0);
        check("stash_ram0", ramMem[0], 8'h11);
        check("stash_ram1", ramMem[1], 8'h22);

        ramMem[0] = 8'hA5;
        stallN = 3;
        runXfer("fetch", reu_pkg::XFER_FETCH, 1, 1, 1'b0, 1'b0);
        stallN = 0;
        check("fetch_setup", rdRise - dmaRise, SETUP_CYC);
        check("fetch_c64", c64Mem[0], 8'hA5);

        c64Mem[0] = 8'h33;
        ramMem[0] = 8'h33;
        c64Mem[1] = 8'h10;
        ramMem[1] = 8'h11;
        c64Mem[2] = 8'h44;
        ramMem[2] = 8'h44;
        runXfer("verify", reu_pkg::XFER_VERIFY, 3, 1, 1'b0, 1'b0);

        c64Mem[0] = 8'h5A;
        ramMem[0] = 8'hC3;
        runXfer("swap", reu_pkg::XFER_SWAP, 1, 2, 1'b0, 1'b0);

        fillRand();
        ca = 0;
        reua = 0;
        len = 17'd4;
        ackDelay = 1000;
        baRand = 1'b0;
        @(posedge PHI2);
        bus.Execute = 1'b1;
        bus.XferType = reu_pkg::XFER_STASH;
        @(posedge PHI2);
        bus.Execute = 1'b0;
        for (int i = 0; i < 50 && !bus.RAMWR; i++) @(posedge PHI2);
        check("rstmid_ramwr", bus.RAMWR, 1'b1);
        #3 Reset = 1'b1;
        #1;
        check("rstmid_ctl", {bus.DMA, bus.Busy, bus.RAMRD, bus.RAMWR, bus.C64WE}, 5'd0);
        check("rstmid_data", {bus.C64DOut, bus.RAMDOut}, 16'd0);
        got.delete();
        bus.RAMAck = 1'b0;
        ramWait = 0;
        repeat (3) @(posedge PHI2);
        #3 Reset = 1'b0;
        repeat (5) @(posedge PHI2);
        #2;
        check("rstmid_noend", got.size(), 0);
        check("rstmid_idle", bus.Busy, 1'b0);
        fillRand();
        runXfer("after_rst", reu_pkg::XFER_STASH, 3, 1, 1'b0, 1'b0);

        fillRand();
        runXfer("busy_exec", reu_pkg::XFER_FETCH, 2, 2, 1'b0, 1'b1);

        for (int k = 0; k < 8; k++) begin
            fillRand();
            runXfer($sformatf("rnd%0d", k), 2'($urandom_range(0, 3)), $urandom_range(1, 5),
                    $urandom_range(0, 3), 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
